instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 15'h0000, the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port imem_req, output, 1 bit: single-cycle instruction-memory read strobe.
REQ-005 The block SHALL have port imem_addr, output, 15 bits: word address of the read.
REQ-006 The block SHALL have port imem_rdata, input, 32 bits: returned instruction word.
REQ-007 The block SHALL have port imem_rvalid, input, 1 bit: imem_rdata valid this cycle.
REQ-008 The block SHALL have port inst, output, 32 bits: instruction to the decoder's inst input.
REQ-009 The block SHALL have port inst_pc, output, 15 bits: address inst was fetched from.
REQ-010 The block SHALL have port inst_valid, output, 1 bit: inst/inst_pc valid.
REQ-011 The block SHALL have port inst_ready, input, 1 bit: downstream accepts inst this cycle.
REQ-012 The block SHALL have port redirect, input, 1 bit: a branch/jump changes the fetch stream.
REQ-013 The block SHALL have port redirect_addr, input, 15 bits: new fetch address, sampled when redirect=1.
REQ-014 The block SHALL have port fetch_count, output, 16 bits: count of instructions delivered (valid&ready), wrapping.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, FETCH, WAIT, HOLD; one request outstanding at most.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-017 In FETCH the block SHALL drive imem_req=1 and imem_addr=pc for one cycle, then go to WAIT.
REQ-018 imem_req SHALL be 0 in every state other than FETCH; imem_addr SHALL equal pc at all times.
REQ-019 In WAIT, on imem_rvalid=1 with no pending discard, the block SHALL capture imem_rdata into inst, set inst_pc=pc, set pc=pc+1 (15-bit, 15'h7FFF wraps to 15'h0000), assert inst_valid next cycle, and go to HOLD.
REQ-020 In WAIT, imem_rvalid=0 SHALL hold the state indefinitely, with no timeout.
REQ-021 imem_rvalid SHALL be ignored outside WAIT.
REQ-022 In HOLD, inst, inst_pc and inst_valid=1 SHALL remain stable until inst_valid&inst_ready.
REQ-023 On a HOLD transfer, the block SHALL clear inst_valid, increment fetch_count (16'hFFFF wraps to 0), and go to FETCH.
REQ-024 Minimum spacing between delivered instructions SHALL be 3 cycles: FETCH, WAIT, HOLD.
REQ-025 On redirect in FETCH or HOLD, the block SHALL set pc=redirect_addr, clear inst_valid next cycle, and go to FETCH; any imem_req issued that same FETCH cycle SHALL be marked for discard.
REQ-026 On redirect in WAIT, the block SHALL set pc=redirect_addr and set a discard flag.
REQ-027 The next imem_rvalid after a discard is flagged SHALL be dropped: no capture, no pc increment; the discard flag SHALL clear and the FSM SHALL go to FETCH.
REQ-028 If redirect and imem_rvalid coincide in WAIT, the response SHALL be dropped and pc SHALL become redirect_addr.
REQ-029 If redirect and a HOLD transfer coincide, the transfer SHALL complete (fetch_count increments) and pc SHALL become redirect_addr.
REQ-030 redirect in IDLE SHALL update pc only; the FSM SHALL still proceed to FETCH.

Reset
REQ-031 On rst_n=0, the block SHALL immediately (asynchronously) set state=IDLE, pc=RESET_PC, inst=32'h0, inst_pc=15'h0, inst_valid=0, imem_req=0, fetch_count=0, and discard flag=0.
REQ-032 On reset asserted mid-WAIT or mid-HOLD, the block SHALL lose the in-flight response and held instruction; a late imem_rvalid after reset release SHALL be ignored, since the FSM is in IDLE.

Verification
REQ-033 Reset then memory returning 32'he208_c000 one cycle after request, with inst_ready=1 -> imem_req at addr 0; inst=32'he208_c000, inst_pc=0, inst_valid for 1 cycle; fetch_count=1; next req at addr 1.
REQ-034 Back-pressure: inst_ready=0 for 5 cycles with inst=32'h6118_0004 held -> inst/inst_pc stable, no imem_req, fetch_count unchanged until ready.
REQ-035 Redirect in WAIT to 15'h0100, then rvalid with 32'h2300_0000 -> word dropped, inst_valid stays 0, next req at 15'h0100.
REQ-036 Redirect coinciding with a HOLD transfer, redirect_addr=15'h0020 -> fetch_count increments and next imem_addr=15'h0020.
REQ-037 RESET_PC=15'h7FFF, one delivered instruction -> next imem_addr=15'h0000.
REQ-038 rst_n pulsed low during WAIT, then rvalid after release -> outputs at reset values, rvalid ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem read, single-entry output holding register,
// redirect handling with a discard flag for responses that belong to the old stream.
module instr_fetch #(
    parameter logic [14:0] RESET_PC = 15'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] inst,
    output logic [14:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [14:0] redirect_addr,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [14:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [14:0] inst_pc_q, inst_pc_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;
    logic        discard_q, discard_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            inst_pc_q <= 15'h0;
            valid_q   <= 1'b0;
            count_q   <= 16'h0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        count_d   = count_q;
        discard_d = discard_q;

        case (state_q)
            StIdle: begin
                state_d = StFetch;
                if (redirect) pc_d = redirect_addr;
            end
            StFetch: begin
                state_d = StWait;
                if (redirect) begin
                    // The request issued this cycle belongs to the old stream.
                    pc_d      = redirect_addr;
                    valid_d   = 1'b0;
                    discard_d = 1'b1;
                    state_d   = StFetch;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    state_d   = StFetch;
                    discard_d = 1'b0;
                    if (redirect) begin
                        pc_d = redirect_addr;
                    end else if (!discard_q) begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + 15'd1;
                        valid_d   = 1'b1;
                        state_d   = StHold;
                    end
                end else if (redirect) begin
                    pc_d      = redirect_addr;
                    discard_d = 1'b1;
                end
            end
            StHold: begin
                if (inst_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    state_d = StFetch;
                end
                // Redirect without a transfer drops the held instruction.
                if (redirect) begin
                    pc_d    = redirect_addr;
                    valid_d = 1'b0;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table of normal fetches plus hand-written redirect,
// back-pressure, address-wrap and mid-transaction reset sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_req2;
    logic [14:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] inst, inst2;
    logic [14:0] inst_pc, inst_pc2;
    logic        inst_valid, inst_valid2;
    logic        inst_ready;
    logic        redirect;
    logic [14:0] redirect_addr;
    logic [15:0] fetch_count, fetch_count2;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .redirect(redirect),
        .redirect_addr(redirect_addr), .fetch_count(fetch_count)
    );

    // Same inputs, top-of-memory reset PC: runs in lockstep with dut.
    instr_fetch #(.RESET_PC(15'h7FFF)) dut_top (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .inst(inst2), .inst_pc(inst_pc2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready), .redirect(redirect),
        .redirect_addr(redirect_addr), .fetch_count(fetch_count2)
    );

    typedef struct {
        logic [31:0] word;
        logic [14:0] addr;
        logic [15:0] count;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [14:0] exp_addr);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("req_seen", {31'h0, imem_req}, 32'h1);
        check("req_addr", {17'h0, imem_addr}, {17'h0, exp_addr});
    endtask

    // Issue request, return word one cycle later, land in HOLD.
    task automatic do_request(input logic [14:0] exp_addr, input logic [31:0] word);
        wait_req(exp_addr);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        step();
        imem_rvalid = 1'b0;
        check("inst_valid", {31'h0, inst_valid}, 32'h1);
        check("inst", inst, word);
        check("inst_pc", {17'h0, inst_pc}, {17'h0, exp_addr});
    endtask

    task automatic deliver(input logic [15:0] exp_count);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("fetch_count", {16'h0, fetch_count}, {16'h0, exp_count});
        check("valid_clear", {31'h0, inst_valid}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{word: 32'he208_c000, addr: 15'h0000, count: 16'd1};
        vecs[1] = '{word: 32'h0000_0013, addr: 15'h0001, count: 16'd2};
        vecs[2] = '{word: 32'hffff_ffff, addr: 15'h0002, count: 16'd3};
        vecs[3] = '{word: 32'h1234_5678, addr: 15'h0003, count: 16'd4};

        rst_n = 1'b0;
        imem_rdata = 32'h0;
        imem_rvalid = 1'b0;
        inst_ready = 1'b0;
        redirect = 1'b0;
        redirect_addr = 15'h0;
        step();
        step();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_count", {16'h0, fetch_count}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_addr_top", {17'h0, imem_addr2}, 32'h7FFF);

        // One IDLE cycle after release, then FETCH.
        rst_n = 1'b1;
        check("idle_no_req", {31'h0, imem_req}, 32'h0);
        step();
        check("fetch_after_idle", {31'h0, imem_req}, 32'h1);

        for (int i = 0; i < 4; i++) begin
            do_request(vecs[i].addr, vecs[i].word);
            deliver(vecs[i].count);
            if (i == 0) begin
                check("top_inst_pc", {17'h0, inst_pc2}, 32'h7FFF);
                check("top_wrap_addr", {17'h0, imem_addr2}, 32'h0);
            end
        end

        // Back-pressure for 5 cycles.
        do_request(15'h0004, 32'h6118_0004);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_inst", inst, 32'h6118_0004);
            check("bp_pc", {17'h0, inst_pc}, 32'h4);
            check("bp_valid", {31'h0, inst_valid}, 32'h1);
            check("bp_no_req", {31'h0, imem_req}, 32'h0);
            check("bp_count", {16'h0, fetch_count}, 32'd4);
        end
        deliver(16'd5);

        // Redirect in WAIT, then the stale response arrives.
        wait_req(15'h0005);
        step();
        redirect = 1'b1;
        redirect_addr = 15'h0100;
        step();
        redirect = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h2300_0000;
        step();
        imem_rvalid = 1'b0;
        check("drop_valid", {31'h0, inst_valid}, 32'h0);
        check("drop_count", {16'h0, fetch_count}, 32'd5);
        wait_req(15'h0100);

        // Redirect coinciding with a HOLD transfer.
        do_request(15'h0100, 32'haaaa_5555);
        inst_ready = 1'b1;
        redirect = 1'b1;
        redirect_addr = 15'h0020;
        step();
        inst_ready = 1'b0;
        redirect = 1'b0;
        check("hold_redir_count", {16'h0, fetch_count}, 32'd6);
        check("hold_redir_valid", {31'h0, inst_valid}, 32'h0);
        wait_req(15'h0020);

        // Redirect coinciding with rvalid in WAIT.
        step();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hbad0_0001;
        redirect = 1'b1;
        redirect_addr = 15'h0040;
        step();
        imem_rvalid = 1'b0;
        redirect = 1'b0;
        check("coinc_valid", {31'h0, inst_valid}, 32'h0);
        do_request(15'h0040, 32'h0badc0de);
        deliver(16'd7);

        // Redirect in HOLD without ready drops the held instruction.
        do_request(15'h0041, 32'h5555_aaaa);
        redirect = 1'b1;
        redirect_addr = 15'h0060;
        step();
        redirect = 1'b0;
        check("hold_drop_valid", {31'h0, inst_valid}, 32'h0);
        check("hold_drop_count", {16'h0, fetch_count}, 32'd7);
        wait_req(15'h0060);

        // Reset pulse mid-WAIT, late response after release.
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        check("mid_rst_addr", {17'h0, imem_addr}, 32'h0);
        check("mid_rst_count", {16'h0, fetch_count}, 32'h0);
        check("mid_rst_inst_pc", {17'h0, inst_pc}, 32'h0);
        step();
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hdead_beef;
        step();
        imem_rvalid = 1'b0;
        check("late_rvalid_valid", {31'h0, inst_valid}, 32'h0);
        check("late_rvalid_inst", inst, 32'h0);
        do_request(15'h0000, 32'h0100_0093);
        deliver(16'd1);
        check("post_rst_next", {17'h0, imem_addr}, 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
